// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Purpose
//   Operand forwarding and load-use hazard detection for an in-order pipeline.
//   The unit keeps a shadow copy of the instructions that sit behind decode
//   (stage 0 = EX, stage 1 = MEM, stage DEPTH-1 = WB). For every decode
//   source port it finds the youngest in-flight writer of that register and
//   either forwards its result or, for a load still in EX, requests a stall.
//
// Parameters
//   DATA_W  datapath width
//   REG_AW  register-address width
//   NUM_RD  number of decode source read ports
//   DEPTH   tracked stages after decode, legal range 2..8
//
// Ports
//   CLK         rising-edge clock
//   nRST        asynchronous active-low reset
//   id_valid    decode-stage instruction valid
//   id_rsel     source register per port, port p at [p*REG_AW +: REG_AW]
//   id_wen      decode instruction writes a register
//   id_load     decode instruction is a load
//   id_wsel     decode destination register
//   ex_result   stage-0 ALU result for the current cycle
//   mem_rdata   stage-1 load data for the current cycle
//   stall_in    external pipeline freeze (highest priority, nothing shifts)
//   flush       squash the decode instruction (a bubble enters stage 0)
//   fwd_data    forwarded operand per port, port p at [p*DATA_W +: DATA_W]
//   fwd_en      port p is using fwd_data
//   hz_stall    load-use hazard; decode must hold
//   stall_cnt   (HAZARD_FWD_STATS_EN only) saturating count of cycles in
//               which hz_stall=1 and stall_in=0
//
// Configuration
//   Define HAZARD_FWD_STATS_EN to add the stall_cnt output and its counter.
//   Without it the port and the counter do not exist.
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       id_valid,
  input  logic [NUM_RD*REG_AW-1:0]   id_rsel,
  input  logic                       id_wen,
  input  logic                       id_load,
  input  logic [REG_AW-1:0]          id_wsel,
  input  logic [DATA_W-1:0]          ex_result,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       stall_in,
  input  logic                       flush,
  output logic [NUM_RD*DATA_W-1:0]   fwd_data,
  output logic [NUM_RD-1:0]          fwd_en,
  output logic                       hz_stall
`ifdef HAZARD_FWD_STATS_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int SIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One shadow-pipeline slot.
  typedef struct packed {
    logic              valid;
    logic              wen;
    logic              load;
    logic [REG_AW-1:0] wsel;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            stage_q  [DEPTH];
  entry_t            stage_d  [DEPTH];

  // Per-port winner of the priority search.
  logic [NUM_RD-1:0] port_hit;
  logic [SIDX_W-1:0] port_win [NUM_RD];
  entry_t            win_e    [NUM_RD];
  logic [NUM_RD-1:0] port_hz;
  logic [DATA_W-1:0] port_val [NUM_RD];

  logic              fill;

  // An entry supplies a port when it is a live register writer of the same,
  // non-zero register. Register 0 is hard-wired and never forwarded.
  function automatic logic entry_match(input entry_t e, input logic [REG_AW-1:0] rsel);
    return e.valid && e.wen && (e.wsel == rsel) && (rsel != '0);
  endfunction

  // ---------------------------------------------------------------------------
  // Priority search: scan from oldest to youngest so the youngest match is the
  // last one written and therefore wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that skips an assignment would otherwise infer a latch.
    for (int p = 0; p < NUM_RD; p++) begin
      port_hit[p] = 1'b0;
      port_win[p] = '0;
      win_e[p]    = '0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (entry_match(stage_q[s], id_rsel[p*REG_AW +: REG_AW])) begin
          port_hit[p] = 1'b1;
          port_win[p] = SIDX_W'(s);
          win_e[p]    = stage_q[s];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Source selection and hazard detection.
  //   stage 0 ALU op : result is only on ex_result this cycle
  //   stage 1 load   : result is only on mem_rdata this cycle
  //   stage 0 load   : data not available yet -> stall decode
  //   anything else  : value already captured in the shadow entry
  // ---------------------------------------------------------------------------
  always_comb begin
    hz_stall = 1'b0;
    fwd_en   = '0;
    fwd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      port_hz[p]  = port_hit[p] && (port_win[p] == '0) && win_e[p].load && id_valid;
      port_val[p] = win_e[p].data;
      if ((port_win[p] == '0) && !win_e[p].load) begin
        port_val[p] = ex_result;
      end else if ((port_win[p] == SIDX_W'(1)) && win_e[p].load) begin
        port_val[p] = mem_rdata;
      end

      if (port_hit[p] && !port_hz[p]) begin
        fwd_en[p]                      = 1'b1;
        fwd_data[p*DATA_W +: DATA_W]   = port_val[p];
      end
      if (port_hz[p]) begin
        hz_stall = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next shadow-pipeline contents for an advancing cycle. A load-use hazard or
  // a flush both turn the decode slot into a bubble.
  // ---------------------------------------------------------------------------
  assign fill = id_valid && !hz_stall && !flush;

  always_comb begin
    stage_d[0] = '0;
    if (fill) begin
      stage_d[0].valid = 1'b1;
      stage_d[0].wen   = id_wen;
      stage_d[0].load  = id_load;
      stage_d[0].wsel  = id_wsel;
    end

    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
      // Results only live on the bus for one cycle, so latch them as the
      // producing instruction leaves the stage that generates them.
      if ((i == 1) && !stage_q[0].load) begin
        stage_d[i].data = ex_result;
      end
      if ((i == 2) && stage_q[1].load) begin
        stage_d[i].data = mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow-pipeline registers. stall_in freezes every entry, which also makes
  // it dominate a simultaneous flush.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: the entry array is reset as a whole, data included, so a
    // stale value can never be forwarded right after reset.
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else if (!stall_in) begin
      // NOTE: sequential state uses non-blocking assignments so every entry
      // shifts from the values held before the edge.
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

`ifdef HAZARD_FWD_STATS_EN
  // Cycles actually lost to load-use hazards; frozen cycles are not counted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (hz_stall && !stall_in && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, datapath width; REG_AW, default 5, register-address width; NUM_RD, default 2, source read ports; DEPTH, default 3, tracked stages after decode (stage 0 = EX, 1 = MEM, DEPTH-1 = WB), legal range 2..8.
REQ-002 CLK  input  1  rising-edge clock; the block has one clock.
REQ-003 nRST  input  1  asynchronous active-low reset.
REQ-004 id_valid  input  1  decode-stage instruction valid.
REQ-005 id_rsel  input  NUM_RD*REG_AW  source register per port; port p is at bits [p*REG_AW +: REG_AW].
REQ-006 id_wen, id_load  input  1 each  decode instruction writes a register; decode instruction is a load.
REQ-007 id_wsel  input  REG_AW  decode destination register.
REQ-008 ex_result  input  DATA_W  stage-0 ALU result for the current cycle.
REQ-009 mem_rdata  input  DATA_W  stage-1 load data for the current cycle.
REQ-010 stall_in, flush  input  1 each  external pipeline freeze; squash of the decode instruction.
REQ-011 fwd_data  output  NUM_RD*DATA_W  forwarded operand per port.
REQ-012 fwd_en  output  NUM_RD  port p is using fwd_data.
REQ-013 hz_stall  output  1  load-use hazard; decode must hold.

Function
REQ-014 Shadow pipeline: DEPTH entries SHALL each hold {valid, wen, load, wsel, data}.
REQ-015 Match SHALL mean: entry valid and wen, wsel equal to the port rsel, and rsel non-zero; register 0 SHALL never match.
REQ-016 Priority: if several entries match, the lowest stage index (youngest) SHALL win.
REQ-017 Forward source: winning stage 0 non-load SHALL use ex_result; winning stage 1 load SHALL use mem_rdata; any other winner SHALL use the stored entry data.
REQ-018 Hazard: if the winner is a stage-0 load and id_valid=1, hz_stall SHALL be 1 and fwd_en for that port SHALL be 0.
REQ-019 Unforwarded ports: with no match, fwd_en=0 and fwd_data=0 for that port.
REQ-020 Timing: fwd_data, fwd_en and hz_stall SHALL be combinational in the same cycle.
REQ-021 Hold: when stall_in=1, all entries SHALL hold.
REQ-022 Shift: when stall_in=0, entry i SHALL load entry i-1 and the DEPTH-1 entry SHALL retire.
REQ-023 Capture on shift: stage 0 to 1 non-load SHALL store ex_result; stage 1 to 2 load SHALL store mem_rdata; all other moves SHALL copy data.
REQ-024 Stage-0 fill: stage 0 SHALL load the decode instruction iff id_valid=1, hz_stall=0 and flush=0; otherwise it SHALL load a bubble (valid=0).
REQ-025 Simultaneous flush and hz_stall: a bubble SHALL be inserted.
REQ-026 Simultaneous stall_in and flush: stall_in wins; nothing shifts.

Reset
REQ-027 nRST=0 SHALL clear every entry valid bit and all stored data at once, independent of CLK.
REQ-028 During reset, fwd_en=0, fwd_data=0 and hz_stall=0.
REQ-029 Reset during an active hazard SHALL drop it the same cycle.

Configuration
REQ-030 With macro HAZARD_FWD_STATS_EN defined, output stall_cnt (16 bits) SHALL count cycles where hz_stall=1 and stall_in=0, saturating at 0xFFFF and reset to 0 by nRST.
REQ-031 Without the macro, stall_cnt and its counter SHALL be absent.

Verification
REQ-032 Stage-0 ALU forward: stage 0 add wsel=3, ex_result=0x11; decode rsel0=3 -> fwd_en[0]=1, fwd_data0=0x11, hz_stall=0.
REQ-033 Load-use hazard: stage 0 load wsel=4, decode rsel1=4 -> hz_stall=1, fwd_en[1]=0; next edge stage 0 is a bubble; then fwd_data1=mem_rdata (0xCAFE) and hz_stall=0.
REQ-034 Priority: stage 2 wsel=5 data 0xA, stage 1 non-load wsel=5 data 0xB, decode rsel0=5 -> fwd_data0=0xB.
REQ-035 Register 0 and freeze: wsel=0 in every stage with rsel=0 -> fwd_en=0; stall_in=1 for 3 cycles -> entries unchanged and outputs constant.
REQ-036 Reset and stats: nRST pulsed mid-hazard -> hz_stall=0 immediately; with HAZARD_FWD_STATS_EN, 3 hazard cycles -> stall_cnt=3.
